ul_agc_gain_ctrl: RTL and testbench
===================================

Name: ul_agc_gain_ctrl

Overview:
Closed-loop gain controller for the uplink TDL AGC path.
- Measures mean I/Q power per antenna from the TDM-interleaved uplink stream, XNUM antennas in round-robin slots.
- Compares each mean against high/low thresholds and steps each antenna's gain-table index.
- Publishes the new indices only at a frame head, as the per-antenna gain words the AGC datapath consumes.
- Manual mode: when disabled, passes a software initial index through unchanged.

Parameters:
XNUM, 4, number of interleaved antennas (slots 0..XNUM-1, max 4)
WIN_LOG2, 12, log2 of measurement rounds per window
ACC_W, 48, per-antenna power accumulator width
IDX_MAX, 255, maximum gain-table index

Ports:
clk_245  in  1  datapath clock
asy_rst  in  1  reset
i_data  in  32  sample, I=[31:16], Q=[15:0], two's complement
i_data_valid  in  1  sample qualifier
i_fram_hd  in  1  frame head, one-cycle pulse, marks slot 0
i_enable  in  1  1=closed loop, 0=manual
i_idx_init  in  8  manual/initial gain index
i_step  in  4  index step per update (0 = hold)
i_thr_hi  in  32  mean-power upper threshold
i_thr_lo  in  32  mean-power lower threshold
o_a0_gain..o_a3_gain  out  16 each  gain words, [7:0]=index, [15:8]=0
o_upd_pulse  out  1  one cycle when new gains are applied
o_state  out  3  FSM state, debug

Interface rule: reset asy_rst, asynchronous, active-high; clock clk_245.

Behaviour:
Reset values:
- All gain outputs, o_upd_pulse and accumulators are 0.
- o_state is IDLE (0).

Slot counter:
- Set to 0 on the cycle i_fram_hd=1.
- Otherwise increments every clock and wraps at XNUM-1, independent of i_data_valid.

Power pipeline:
- P1 registers I*I and Q*Q (signed 16x16, 32-bit unsigned results).
- P2 registers p = sum (33 bit).
- P3 adds p into acc[slot] using the slot tag delayed by 2 cycles, saturating at 2^ACC_W-1.
- A sample enters only if i_data_valid=1 and state=ACC at P1. Otherwise the zero-power bubble is not accumulated.

FSM states: IDLE=0, ACC=1, DRAIN=2, EVAL=3, WAIT_HD=4.
- IDLE: all gain outputs follow i_idx_init each cycle. On i_fram_hd with i_enable=1: clear accs and round counter, go to ACC. The head cycle's sample is accepted.
- ACC: round counter increments when slot==XNUM-1. When it reaches 2^WIN_LOG2, go to DRAIN.
- DRAIN: 3 cycles, letting the pipeline flush; then EVAL.
- EVAL: one antenna per cycle, k=0..XNUM-1.
  - mean_k = acc[k] >> WIN_LOG2, saturated to 32 bits.
  - If mean_k > i_thr_hi: next_k = max(idx_k - i_step, 0).
  - Else if mean_k < i_thr_lo: next_k = min(idx_k + i_step, IDX_MAX).
  - Else next_k = idx_k.
  - Checks are strict, so equality holds. If thr_lo > thr_hi, the high check wins.
  - After antenna XNUM-1, go to WAIT_HD.
- WAIT_HD: on i_fram_hd, copy next_k to the outputs, pulse o_upd_pulse for 1 cycle (the cycle after the head), clear accs, go to ACC.

Enable and reset:
- i_enable=0 in any state: next cycle go to IDLE, discard pending next_k, clear accs.
- The idx_k seed when leaving IDLE is i_idx_init.
- i_fram_hd during ACC/DRAIN/EVAL: realigns the slot counter only; it does not restart the window.
- asy_rst mid-window: immediate return to reset values.

Unused outputs and sampling:
- Gain outputs for antennas >= XNUM stay 0, except in IDLE where they follow i_idx_init.
- Thresholds and i_step are sampled during EVAL.

Test Plan:
Bench configuration for all scenarios: WIN_LOG2=2, XNUM=4, i_idx_init=100, i_step=2, i_thr_hi=2^23, i_thr_lo=2^20.
1. Enable, constant I=0x1000, Q=0, valid=1 on all slots -> mean=2^24 per antenna. After the window, at the next frame head all gains =0x0062 and o_upd_pulse=1 for one cycle. After the next window they become 0x0060.
2. I=Q=0x0400 (p=2^21, between thresholds) -> gains stay 0x0064. The update pulse still fires at each applied frame head.
3. Zero input, i_idx_init=254 -> next index 255, then held at 255 (IDX_MAX clamp). With i_thr_hi=0, i_step=2 and idx 1 -> clamps to 0.
4. Only slot 2 fed 0x7FFF/0x7FFF, other slots zero -> a2 decrements, a0/a1/a3 increment. This verifies the slot-tag alignment through the pipeline.
5. i_enable dropped in WAIT_HD -> no o_upd_pulse, outputs return to i_idx_init the next cycle, o_state=0.
6. asy_rst asserted mid-ACC -> all outputs 0 immediately. After release, outputs = i_idx_init on the first clock.

Source files
------------

// File: rtl/ul_agc_gain_ctrl_if.sv
// rtl/ul_agc_gain_ctrl_if.sv - uplink sample stream bundle for the AGC gain controller
//
// Purpose: carries the TDM-interleaved uplink I/Q stream and its frame head.
// Signals:
//   i_data        32  sample, I=[31:16], Q=[15:0], two's complement
//   i_data_valid   1  sample qualifier
//   i_fram_hd      1  one-cycle frame head pulse, marks slot 0
// Modports: master drives the stream, slave (the gain controller) consumes it.
interface ul_agc_gain_ctrl_if;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        i_fram_hd;

    modport master (output i_data, output i_data_valid, output i_fram_hd);
    modport slave  (input  i_data, input  i_data_valid, input  i_fram_hd);
endinterface

// File: rtl/ul_agc_gain_ctrl.sv
// rtl/ul_agc_gain_ctrl.sv - closed-loop per-antenna gain index controller for the uplink AGC
//
// Purpose: measures mean I/Q power per interleaved antenna over a window of
// 2^WIN_LOG2 rounds, steps each antenna's gain-table index against high/low
// thresholds, and applies the new indices at the following frame head.
// Ports:
//   clk_245, asy_rst       clock, asynchronous active-high reset
//   bus (slave)            i_data / i_data_valid / i_fram_hd stream
//   i_enable               1 = closed loop, 0 = manual (outputs follow i_idx_init)
//   i_idx_init             manual / seed gain index
//   i_step                 index step per update (0 = hold)
//   i_thr_hi, i_thr_lo     mean-power thresholds
//   o_a0_gain..o_a3_gain   gain words, [7:0] = index, [15:8] = 0
//   o_upd_pulse            one cycle when new gains are applied
//   o_state                FSM state (debug)
module ul_agc_gain_ctrl #(
    parameter int XNUM     = 4,
    parameter int WIN_LOG2 = 12,
    parameter int ACC_W    = 48,
    parameter int IDX_MAX  = 255
) (
    input  logic                    clk_245,
    input  logic                    asy_rst,
    ul_agc_gain_ctrl_if.slave       bus,
    input  logic                    i_enable,
    input  logic [7:0]              i_idx_init,
    input  logic [3:0]              i_step,
    input  logic [31:0]             i_thr_hi,
    input  logic [31:0]             i_thr_lo,
    output logic [15:0]             o_a0_gain,
    output logic [15:0]             o_a1_gain,
    output logic [15:0]             o_a2_gain,
    output logic [15:0]             o_a3_gain,
    output logic                    o_upd_pulse,
    output logic [2:0]              o_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC     = 3'd1,
        DRAIN   = 3'd2,
        EVAL    = 3'd3,
        WAIT_HD = 3'd4
    } state_t;

    state_t              state;
    logic [1:0]          slot_q, slot;
    logic [WIN_LOG2-1:0] rnd;
    logic [1:0]          dcnt;
    logic [1:0]          ev_k;
    logic [7:0]          gain [4];
    logic [7:0]          nxt  [4];
    logic [ACC_W-1:0]    acc  [4];

    // Slot 0 is the head cycle itself, so realignment is combinational.
    assign slot = bus.i_fram_hd ? 2'd0 : slot_q;

    always_ff @(posedge clk_245 or posedge asy_rst) begin
        if (asy_rst) slot_q <= 2'd0;
        else         slot_q <= (slot == 2'(XNUM - 1)) ? 2'd0 : slot + 2'd1;
    end

    // Window start: leaving IDLE or WAIT_HD on a head. That head's sample belongs to the new window.
    logic head_go, accept, clr_acc;
    assign head_go = bus.i_fram_hd && i_enable && (state == IDLE || state == WAIT_HD);
    assign accept  = bus.i_data_valid && i_enable && (state == ACC || head_go);
    assign clr_acc = !i_enable || head_go;

    // Power pipeline: P1 squares, P2 sums, P3 accumulates with the slot tag delayed alongside.
    logic signed [15:0] di, dq;
    logic signed [31:0] sq_i, sq_q;
    logic [31:0]        p1_i, p1_q;
    logic [32:0]        p2;
    logic               v1, v2;
    logic [1:0]         t1, t2;
    logic [ACC_W:0]     acc_sum;

    assign di      = bus.i_data[31:16];
    assign dq      = bus.i_data[15:0];
    assign sq_i    = 32'(di) * 32'(di);
    assign sq_q    = 32'(dq) * 32'(dq);
    assign acc_sum = {1'b0, acc[t2]} + {{(ACC_W - 32){1'b0}}, p2};

    always_ff @(posedge clk_245 or posedge asy_rst) begin
        if (asy_rst) begin
            p1_i <= '0;
            p1_q <= '0;
            p2   <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            t1   <= '0;
            t2   <= '0;
            for (int k = 0; k < 4; k++) acc[k] <= '0;
        end else begin
            p1_i <= $unsigned(sq_i);
            p1_q <= $unsigned(sq_q);
            v1   <= accept;
            t1   <= slot;
            p2   <= {1'b0, p1_i} + {1'b0, p1_q};
            v2   <= v1 && i_enable;
            t2   <= t1;
            if (clr_acc) begin
                for (int k = 0; k < 4; k++) acc[k] <= '0;
            end else if (v2) begin
                acc[t2] <= acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
            end
        end
    end

    // Evaluation of antenna ev_k against the thresholds.
    logic [ACC_W-1:0] acc_sh;
    logic [31:0]      mean;
    logic [8:0]       up;
    logic [7:0]       g, idx_up, idx_dn, idx_eval;

    always_comb begin
        acc_sh   = acc[ev_k] >> WIN_LOG2;
        mean     = (|acc_sh[ACC_W-1:32]) ? 32'hFFFF_FFFF : acc_sh[31:0];
        g        = gain[ev_k];
        up       = {1'b0, g} + {5'b0, i_step};
        idx_up   = (up > 9'(IDX_MAX)) ? 8'(IDX_MAX) : up[7:0];
        idx_dn   = (g < {4'b0, i_step}) ? 8'd0 : g - {4'b0, i_step};
        // High check first so an inverted threshold pair still steps down.
        if (mean > i_thr_hi)      idx_eval = idx_dn;
        else if (mean < i_thr_lo) idx_eval = idx_up;
        else                      idx_eval = g;
    end

    always_ff @(posedge clk_245 or posedge asy_rst) begin
        if (asy_rst) begin
            state       <= IDLE;
            rnd         <= '0;
            dcnt        <= '0;
            ev_k        <= '0;
            o_upd_pulse <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                gain[k] <= '0;
                nxt[k]  <= '0;
            end
        end else begin
            o_upd_pulse <= 1'b0;
            if (!i_enable) begin
                state <= IDLE;
                for (int k = 0; k < 4; k++) begin
                    gain[k] <= i_idx_init;
                    nxt[k]  <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        for (int k = 0; k < 4; k++)
                            gain[k] <= (bus.i_fram_hd && k >= XNUM) ? 8'd0 : i_idx_init;
                        if (bus.i_fram_hd) begin
                            state <= ACC;
                            rnd   <= '0;
                        end
                    end
                    ACC: begin
                        if (slot == 2'(XNUM - 1)) begin
                            if (rnd == '1) begin
                                state <= DRAIN;
                                dcnt  <= '0;
                            end else begin
                                rnd <= rnd + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        dcnt <= dcnt + 2'd1;
                        if (dcnt == 2'd2) begin
                            state <= EVAL;
                            ev_k  <= '0;
                        end
                    end
                    EVAL: begin
                        nxt[ev_k] <= idx_eval;
                        if (ev_k == 2'(XNUM - 1)) state <= WAIT_HD;
                        else                      ev_k  <= ev_k + 2'd1;
                    end
                    WAIT_HD: begin
                        if (bus.i_fram_hd) begin
                            for (int k = 0; k < 4; k++)
                                gain[k] <= (k < XNUM) ? nxt[k] : 8'd0;
                            o_upd_pulse <= 1'b1;
                            state       <= ACC;
                            rnd         <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_state   = state;
    assign o_a0_gain = {8'h00, gain[0]};
    assign o_a1_gain = {8'h00, gain[1]};
    assign o_a2_gain = {8'h00, gain[2]};
    assign o_a3_gain = {8'h00, gain[3]};
endmodule

// File: tb/tb_ul_agc_gain_ctrl.sv
// tb/tb_ul_agc_gain_ctrl.sv - directed self-checking bench for ul_agc_gain_ctrl
module tb_ul_agc_gain_ctrl;
    logic        clk_245 = 1'b0;
    logic        asy_rst;
    logic        i_enable;
    logic [7:0]  i_idx_init;
    logic [3:0]  i_step;
    logic [31:0] i_thr_hi, i_thr_lo;
    logic [15:0] o_a0_gain, o_a1_gain, o_a2_gain, o_a3_gain;
    logic        o_upd_pulse;
    logic [2:0]  o_state;

    int checks = 0;
    int errors = 0;
    int bslot  = 0;
    logic [15:0] sd_i [4];
    logic [15:0] sd_q [4];

    ul_agc_gain_ctrl_if bus();

    ul_agc_gain_ctrl #(.XNUM(4), .WIN_LOG2(2), .ACC_W(48), .IDX_MAX(255)) dut (
        .clk_245     (clk_245),
        .asy_rst     (asy_rst),
        .bus         (bus),
        .i_enable    (i_enable),
        .i_idx_init  (i_idx_init),
        .i_step      (i_step),
        .i_thr_hi    (i_thr_hi),
        .i_thr_lo    (i_thr_lo),
        .o_a0_gain   (o_a0_gain),
        .o_a1_gain   (o_a1_gain),
        .o_a2_gain   (o_a2_gain),
        .o_a3_gain   (o_a3_gain),
        .o_upd_pulse (o_upd_pulse),
        .o_state     (o_state)
    );

    always #5 clk_245 = ~clk_245;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_gains(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
        chk({tag, ".a0"}, {16'h0, o_a0_gain}, {16'h0, e0});
        chk({tag, ".a1"}, {16'h0, o_a1_gain}, {16'h0, e1});
        chk({tag, ".a2"}, {16'h0, o_a2_gain}, {16'h0, e2});
        chk({tag, ".a3"}, {16'h0, o_a3_gain}, {16'h0, e3});
    endtask

    task automatic set_all(input logic [15:0] di, input logic [15:0] dq);
        for (int k = 0; k < 4; k++) begin
            sd_i[k] = di;
            sd_q[k] = dq;
        end
    endtask

    // One clock: drive the slot's sample, sample outputs 1 ns after the edge.
    task automatic step(input logic hd);
        if (hd) bslot = 0;
        bus.i_fram_hd    = hd;
        bus.i_data       = {sd_i[bslot], sd_q[bslot]};
        bus.i_data_valid = 1'b1;
        @(posedge clk_245);
        #1;
        bslot         = (bslot == 3) ? 0 : bslot + 1;
        bus.i_fram_hd = 1'b0;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step(1'b0);
    endtask

    // From any state: back to IDLE, then one full window applied at the second head.
    task automatic window_from_idle();
        i_enable = 1'b0;
        step(1'b0);
        i_enable = 1'b1;
        step(1'b1);
        run(31);
        step(1'b1);
    endtask

    initial begin
        asy_rst          = 1'b1;
        i_enable         = 1'b0;
        i_idx_init       = 8'd100;
        i_step           = 4'd2;
        i_thr_hi         = 32'h0080_0000;
        i_thr_lo         = 32'h0010_0000;
        bus.i_data       = '0;
        bus.i_data_valid = 1'b0;
        bus.i_fram_hd    = 1'b0;
        set_all(16'h0000, 16'h0000);

        repeat (2) @(posedge clk_245);
        #1;
        chk_gains("reset", 16'h0, 16'h0, 16'h0, 16'h0);
        chk("reset.pulse", {31'h0, o_upd_pulse}, 32'h0);
        chk("reset.state", {29'h0, o_state}, 32'h0);
        asy_rst = 1'b0;
        step(1'b0);
        chk_gains("manual", 16'h0064, 16'h0064, 16'h0064, 16'h0064);

        // 1: strong input, mean 2^24 above thr_hi -> step down twice.
        set_all(16'h1000, 16'h0000);
        i_enable = 1'b1;
        step(1'b1);
        chk("s1.acc_state", {29'h0, o_state}, 32'd1);
        chk_gains("s1.hold_in_window", 16'h0064, 16'h0064, 16'h0064, 16'h0064);
        run(31);
        chk("s1.wait_state", {29'h0, o_state}, 32'd4);
        chk("s1.no_pulse_before_hd", {31'h0, o_upd_pulse}, 32'h0);
        step(1'b1);
        chk_gains("s1.upd1", 16'h0062, 16'h0062, 16'h0062, 16'h0062);
        chk("s1.pulse1", {31'h0, o_upd_pulse}, 32'h1);
        chk("s1.state_after_hd", {29'h0, o_state}, 32'd1);
        step(1'b0);
        chk("s1.pulse_one_cycle", {31'h0, o_upd_pulse}, 32'h0);
        run(30);
        step(1'b1);
        chk_gains("s1.upd2", 16'h0060, 16'h0060, 16'h0060, 16'h0060);
        i_enable = 1'b0;
        step(1'b0);
        chk("s1.disable_state", {29'h0, o_state}, 32'd0);
        chk_gains("s1.disable_gains", 16'h0064, 16'h0064, 16'h0064, 16'h0064);

        // 2: power between thresholds (negative Q exercises signed squaring) -> hold.
        set_all(16'h0400, 16'hFC00);
        i_enable = 1'b1;
        step(1'b1);
        run(31);
        step(1'b1);
        chk_gains("s2.upd1", 16'h0064, 16'h0064, 16'h0064, 16'h0064);
        chk("s2.pulse1", {31'h0, o_upd_pulse}, 32'h1);
        step(1'b0);
        run(30);
        step(1'b1);
        chk_gains("s2.upd2", 16'h0064, 16'h0064, 16'h0064, 16'h0064);
        chk("s2.pulse2", {31'h0, o_upd_pulse}, 32'h1);

        // 2b: per-slot boundaries: ==hi, ==lo, hi+1 region, just below lo.
        sd_i[0] = 16'h0800; sd_q[0] = 16'h0800;
        sd_i[1] = 16'h0400; sd_q[1] = 16'h0000;
        sd_i[2] = 16'h0800; sd_q[2] = 16'h0801;
        sd_i[3] = 16'h03FF; sd_q[3] = 16'h0000;
        window_from_idle();
        chk_gains("s2b.thr_edges", 16'h0064, 16'h0064, 16'h0062, 16'h0066);

        // 3: zero input from 254 -> clamp at IDX_MAX, then hold there.
        set_all(16'h0000, 16'h0000);
        i_idx_init = 8'd254;
        window_from_idle();
        chk_gains("s3.clamp_max", 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF);
        step(1'b0);
        run(30);
        step(1'b1);
        chk_gains("s3.hold_max", 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF);

        // 3b: thr_hi=0 below thr_lo, mean=1 -> high check wins, 1-2 clamps to 0.
        set_all(16'h0001, 16'h0000);
        i_idx_init = 8'd1;
        i_thr_hi   = 32'h0;
        window_from_idle();
        chk_gains("s3.clamp_min", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        i_thr_hi = 32'h0080_0000;

        // 4: only slot 2 loud -> a2 down, others up (slot-tag alignment).
        set_all(16'h0000, 16'h0000);
        sd_i[2]    = 16'h7FFF;
        sd_q[2]    = 16'h7FFF;
        i_idx_init = 8'd100;
        window_from_idle();
        chk_gains("s4.slot2", 16'h0066, 16'h0066, 16'h0062, 16'h0066);

        // 5: enable dropped in WAIT_HD on a head cycle -> no pulse, back to manual.
        set_all(16'h1000, 16'h0000);
        window_from_idle();
        chk_gains("s5.applied", 16'h0062, 16'h0062, 16'h0062, 16'h0062);
        run(31);
        chk("s5.wait_state", {29'h0, o_state}, 32'd4);
        i_idx_init = 8'd50;
        i_enable   = 1'b0;
        step(1'b1);
        chk("s5.state", {29'h0, o_state}, 32'd0);
        chk("s5.no_pulse", {31'h0, o_upd_pulse}, 32'h0);
        chk_gains("s5.manual", 16'h0032, 16'h0032, 16'h0032, 16'h0032);
        step(1'b0);
        chk("s5.no_pulse_late", {31'h0, o_upd_pulse}, 32'h0);

        // 6: asynchronous reset mid-ACC.
        i_idx_init = 8'd100;
        i_enable   = 1'b1;
        step(1'b1);
        run(5);
        chk("s6.acc_state", {29'h0, o_state}, 32'd1);
        asy_rst = 1'b1;
        #1;
        chk_gains("s6.async_reset", 16'h0, 16'h0, 16'h0, 16'h0);
        chk("s6.reset_state", {29'h0, o_state}, 32'd0);
        @(posedge clk_245);
        #1;
        asy_rst = 1'b0;
        step(1'b0);
        chk_gains("s6.after_release", 16'h0064, 16'h0064, 16'h0064, 16'h0064);
        chk("s6.idle_state", {29'h0, o_state}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
